// File: rtl/serial_sign_deserializer.sv
// rtl/serial_sign_deserializer.sv - MSB-first serial-to-parallel word assembler with sign flag
// Shifts accepted bits into a word; on the final bit publishes the word, its sign and a one-cycle strobe.
module serial_sign_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   input  logic                     frame_start,
   output logic [WIDTH-1:0]         data_out,
   output logic                     sign,
   output logic                     data_valid,
   output logic                     busy,
   output logic [$clog2(WIDTH):0]   bit_count
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  shift_q;
   logic [WIDTH-1:0]  shift_d;
   logic [CW-1:0]     count_q;
   logic [WIDTH-1:0]  data_q;
   logic              sign_q;
   logic              valid_q;

   assign shift_d = {shift_q[WIDTH-2:0], bit_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         count_q <= '0;
         data_q  <= '0;
         sign_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (frame_start) begin
            // Realign: a bit arriving with frame_start opens the new word, even if the old one was one bit short.
            if (bit_valid) begin
               shift_q <= shift_d;
               count_q <= CW'(1);
               state_q <= SHIFT;
            end else begin
               count_q <= '0;
               state_q <= IDLE;
            end
         end else if (bit_valid) begin
            case (state_q)
               IDLE: begin
                  shift_q <= shift_d;
                  count_q <= CW'(1);
                  state_q <= SHIFT;
               end
               SHIFT: begin
                  shift_q <= shift_d;
                  if (count_q == LAST_CNT) begin
                     data_q  <= shift_d;
                     sign_q  <= shift_q[WIDTH-2];
                     valid_q <= 1'b1;
                     count_q <= '0;
                     state_q <= IDLE;
                  end else begin
                     count_q <= count_q + CW'(1);
                  end
               end
               default: begin
                  count_q <= '0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign data_out   = data_q;
   assign sign       = sign_q;
   assign data_valid = valid_q;
   assign bit_count  = count_q;
   assign busy       = (count_q != '0);

endmodule
